// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand hazard resolution, load-use stall and ID/EX register.
// Optional FORWARD_EN: EX/MEM forwarding muxes; otherwise stall until the producer retires.
module id_ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_wreg,
    input  logic        id_mem2reg,
    input  logic        id_wmem,
    input  logic        id_aluimm,
    input  logic [3:0]  id_aluc,
    input  logic [31:0] id_imm,
    input  logic [31:0] rf_douts,
    input  logic [31:0] rf_doutt,
    input  logic [31:0] ex_alu,
    input  logic [4:0]  mem_rd,
    input  logic        mem_wreg,
    input  logic        mem_mem2reg,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_mdata,
    input  logic        flush,
    output logic        stall,
    output logic        ex_valid,
    output logic        ex_wreg,
    output logic        ex_mem2reg,
    output logic        ex_wmem,
    output logic        ex_aluimm,
    output logic [4:0]  ex_rd,
    output logic [3:0]  ex_aluc,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm
);

    typedef struct packed {
        logic        valid;
        logic        wreg;
        logic        mem2reg;
        logic        wmem;
        logic        aluimm;
        logic [4:0]  rd;
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } ex_reg_t;

    ex_reg_t     ex_q, ex_d;
    logic        ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic [31:0] opa, opb;

    assign ex_hit_rs  = ex_q.valid & ex_q.wreg & (ex_q.rd != 5'd0) & (ex_q.rd == id_rs);
    assign ex_hit_rt  = ex_q.valid & ex_q.wreg & (ex_q.rd != 5'd0) & (ex_q.rd == id_rt);
    assign mem_hit_rs = mem_wreg & (mem_rd != 5'd0) & (mem_rd == id_rs);
    assign mem_hit_rt = mem_wreg & (mem_rd != 5'd0) & (mem_rd == id_rt);

`ifdef FORWARD_EN
    logic [31:0] mem_val;

    assign mem_val = mem_mem2reg ? mem_mdata : mem_alu;
    assign opa = ex_hit_rs ? ex_alu : (mem_hit_rs ? mem_val : rf_douts);
    assign opb = ex_hit_rt ? ex_alu : (mem_hit_rt ? mem_val : rf_doutt);
    // Only a load in EX cannot be forwarded in time; one bubble clears ex_mem2reg.
    assign stall = reset & id_valid & ex_q.mem2reg &
                   ((id_use_rs & ex_hit_rs) | (id_use_rt & ex_hit_rt));
`else
    logic unused_fwd;

    assign unused_fwd = ^{ex_alu, mem_alu, mem_mdata, mem_mem2reg};
    assign opa = rf_douts;
    assign opb = rf_doutt;
    assign stall = reset & id_valid &
                   ((id_use_rs & (ex_hit_rs | mem_hit_rs)) |
                    (id_use_rt & (ex_hit_rt | mem_hit_rt)));
`endif

    always_comb begin
        ex_d = '0;
        if (!(flush | stall | !id_valid)) begin
            ex_d.valid   = 1'b1;
            ex_d.wreg    = id_wreg;
            ex_d.mem2reg = id_mem2reg;
            ex_d.wmem    = id_wmem;
            ex_d.aluimm  = id_aluimm;
            ex_d.rd      = id_rd;
            ex_d.aluc    = id_aluc;
            ex_d.a       = opa;
            ex_d.b       = opb;
            ex_d.imm     = id_imm;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_wreg    = ex_q.wreg;
    assign ex_mem2reg = ex_q.mem2reg;
    assign ex_wmem    = ex_q.wmem;
    assign ex_aluimm  = ex_q.aluimm;
    assign ex_rd      = ex_q.rd;
    assign ex_aluc    = ex_q.aluc;
    assign ex_a       = ex_q.a;
    assign ex_b       = ex_q.b;
    assign ex_imm     = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow FORWARD_EN when it is defined.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt;
    logic        id_wreg, id_mem2reg, id_wmem, id_aluimm;
    logic [3:0]  id_aluc;
    logic [31:0] id_imm, rf_douts, rf_doutt, ex_alu;
    logic [4:0]  mem_rd;
    logic        mem_wreg, mem_mem2reg;
    logic [31:0] mem_alu, mem_mdata;
    logic        flush;
    logic        stall;
    logic        ex_valid, ex_wreg, ex_mem2reg, ex_wmem, ex_aluimm;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_aluc;
    logic [31:0] ex_a, ex_b, ex_imm;

    typedef struct packed {
        logic        valid;
        logic        wreg;
        logic        mem2reg;
        logic        wmem;
        logic        aluimm;
        logic [4:0]  rd;
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } ex_t;

    ex_t sb[$];
    int  errors = 0;
    int  checks = 0;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_wreg(id_wreg), .id_mem2reg(id_mem2reg), .id_wmem(id_wmem),
        .id_aluimm(id_aluimm), .id_aluc(id_aluc), .id_imm(id_imm),
        .rf_douts(rf_douts), .rf_doutt(rf_doutt), .ex_alu(ex_alu),
        .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_mem2reg(mem_mem2reg),
        .mem_alu(mem_alu), .mem_mdata(mem_mdata), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_mem2reg(ex_mem2reg),
        .ex_wmem(ex_wmem), .ex_aluimm(ex_aluimm), .ex_rd(ex_rd), .ex_aluc(ex_aluc),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm)
    );

    always #5 clock = ~clock;

    function automatic ex_t got();
        return {ex_valid, ex_wreg, ex_mem2reg, ex_wmem, ex_aluimm, ex_rd, ex_aluc, ex_a, ex_b, ex_imm};
    endfunction

    function automatic ex_t mk(input logic v, input logic w, input logic m2r, input logic wm,
                               input logic ai, input logic [4:0] rd, input logic [3:0] aluc,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        return {v, w, m2r, wm, ai, rd, aluc, a, b, imm};
    endfunction

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic [4:0] rd,
                            input logic w, input logic m2r, input logic wm, input logic ai,
                            input logic [3:0] aluc, input logic [31:0] imm,
                            input logic [31:0] ds, input logic [31:0] dt);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_rd = rd; id_wreg = w; id_mem2reg = m2r; id_wmem = wm; id_aluimm = ai;
        id_aluc = aluc; id_imm = imm; rf_douts = ds; rf_doutt = dt;
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic w, input logic m2r,
                             input logic [31:0] alu, input logic [31:0] md);
        mem_rd = rd; mem_wreg = w; mem_mem2reg = m2r; mem_alu = alu; mem_mdata = md;
    endtask

    task automatic test_reset();
        ex_t exp;
        drive_id(1, 18, 19, 0, 0, 2, 1, 1, 0, 1, 4'h0, 32'h10, 32'h111, 32'h222);
        sb.push_back(mk(1, 1, 1, 0, 1, 2, 0, 32'h111, 32'h222, 32'h10));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL rst_pre got=%h exp=%h", got(), exp); end
        // load r2 sits in EX; the hazard must not stall while reset is low
        reset = 1'b0;
        drive_id(1, 2, 2, 1, 1, 9, 1, 0, 0, 0, 4'h3, 32'h1, 32'h5, 32'h6);
        #1; checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=%b", stall, 1'b0); end
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL rst_clear got=%h exp=%h", got(), exp); end
        reset = 1'b1;
    endtask

    task automatic test_ex_forward();
        ex_t exp;
        drive_id(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 4'h2, 32'h0, 32'h11, 32'h22);
        sb.push_back(mk(1, 1, 0, 0, 0, 3, 2, 32'h11, 32'h22, 32'h0));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL exf_prod got=%h exp=%h", got(), exp); end
        ex_alu = 32'h5;
        drive_id(1, 3, 1, 1, 1, 6, 1, 0, 0, 0, 4'h2, 32'h0, 32'h0, 32'h33);
        #1; checks++;
`ifdef FORWARD_EN
        if (stall !== 1'b0) begin errors++; $display("FAIL exf_stall got=%b exp=%b", stall, 1'b0); end
        sb.push_back(mk(1, 1, 0, 0, 0, 6, 2, 32'h5, 32'h33, 32'h0));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL exf_a got=%h exp=%h", got(), exp); end
`else
        if (stall !== 1'b1) begin errors++; $display("FAIL exs_stall1 got=%b exp=%b", stall, 1'b1); end
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL exs_bub1 got=%h exp=%h", got(), exp); end
        drive_mem(3, 1, 0, 32'h5, 32'h0);
        #1; checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL exs_stall2 got=%b exp=%b", stall, 1'b1); end
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL exs_bub2 got=%h exp=%h", got(), exp); end
        drive_mem(0, 0, 0, 32'h0, 32'h0);
        rf_douts = 32'h5;
        #1; checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL exs_stall3 got=%b exp=%b", stall, 1'b0); end
        sb.push_back(mk(1, 1, 0, 0, 0, 6, 2, 32'h5, 32'h33, 32'h0));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL exs_a got=%h exp=%h", got(), exp); end
`endif
    endtask

    task automatic test_mem_forward();
        ex_t exp;
        drive_id(0, 6, 6, 1, 1, 7, 1, 0, 0, 0, 4'h1, 32'h0, 32'h1, 32'h2);
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL memf_invalid got=%h exp=%h", got(), exp); end
        drive_mem(4, 1, 1, 32'h1234, 32'hDEADBEEF);
        drive_id(1, 9, 4, 1, 1, 10, 1, 0, 0, 1, 4'h3, 32'h40, 32'h99, 32'hAAAA);
        #1; checks++;
`ifdef FORWARD_EN
        if (stall !== 1'b0) begin errors++; $display("FAIL memf_stall got=%b exp=%b", stall, 1'b0); end
`else
        if (stall !== 1'b1) begin errors++; $display("FAIL mems_stall got=%b exp=%b", stall, 1'b1); end
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL mems_bub got=%h exp=%h", got(), exp); end
        drive_mem(0, 0, 0, 32'h0, 32'h0);
        rf_doutt = 32'hDEADBEEF;
`endif
        sb.push_back(mk(1, 1, 0, 0, 1, 10, 3, 32'h99, 32'hDEADBEEF, 32'h40));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL memf_load got=%h exp=%h", got(), exp); end
        // EX producer of r4 must win over the MEM load of r4
        drive_mem(0, 0, 0, 32'h0, 32'h0);
        drive_id(1, 16, 17, 0, 0, 4, 1, 0, 0, 0, 4'h1, 32'h0, 32'h1, 32'h2);
        sb.push_back(mk(1, 1, 0, 0, 0, 4, 1, 32'h1, 32'h2, 32'h0));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL memf_prod got=%h exp=%h", got(), exp); end
        drive_mem(4, 1, 1, 32'h1234, 32'hDEADBEEF);
        ex_alu = 32'h7;
        drive_id(1, 9, 4, 1, 1, 10, 1, 0, 0, 1, 4'h3, 32'h40, 32'h99, 32'hAAAA);
        #1; checks++;
`ifdef FORWARD_EN
        if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=%b", stall, 1'b0); end
        sb.push_back(mk(1, 1, 0, 0, 1, 10, 3, 32'h99, 32'h7, 32'h40));
`else
        if (stall !== 1'b1) begin errors++; $display("FAIL prio_stall got=%b exp=%b", stall, 1'b1); end
        sb.push_back('0);
`endif
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL prio_b got=%h exp=%h", got(), exp); end
        drive_mem(5, 1, 0, 32'h1234, 32'hFFFF);
        drive_id(1, 5, 20, 1, 1, 11, 1, 0, 0, 0, 4'h4, 32'h0, 32'h50, 32'h60);
        #1; checks++;
`ifdef FORWARD_EN
        if (stall !== 1'b0) begin errors++; $display("FAIL memalu_stall got=%b exp=%b", stall, 1'b0); end
        sb.push_back(mk(1, 1, 0, 0, 0, 11, 4, 32'h1234, 32'h60, 32'h0));
`else
        if (stall !== 1'b1) begin errors++; $display("FAIL memalu_stall got=%b exp=%b", stall, 1'b1); end
        sb.push_back('0);
`endif
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL memalu_a got=%h exp=%h", got(), exp); end
        drive_mem(0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_load_use();
        ex_t exp;
        drive_id(1, 18, 19, 0, 0, 2, 1, 1, 0, 1, 4'h0, 32'h8, 32'h0, 32'h0);
        sb.push_back(mk(1, 1, 1, 0, 1, 2, 0, 32'h0, 32'h0, 32'h8));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL lu_load got=%h exp=%h", got(), exp); end
        ex_alu = 32'hBAD;
        drive_id(1, 20, 2, 1, 1, 0, 0, 0, 1, 1, 4'h0, 32'h4, 32'h100, 32'h0);
        #1; checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=%b", stall, 1'b1); end
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL lu_bubble got=%h exp=%h", got(), exp); end
        drive_mem(2, 1, 1, 32'hBAD, 32'hCAFEF00D);
        #1; checks++;
`ifdef FORWARD_EN
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got=%b exp=%b", stall, 1'b0); end
`else
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_mem got=%b exp=%b", stall, 1'b1); end
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL lu_bubble2 got=%h exp=%h", got(), exp); end
        drive_mem(0, 0, 0, 32'h0, 32'h0);
        rf_doutt = 32'hCAFEF00D;
`endif
        sb.push_back(mk(1, 0, 0, 1, 1, 0, 0, 32'h100, 32'hCAFEF00D, 32'h4));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL lu_data got=%h exp=%h", got(), exp); end
        drive_mem(0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_unused();
        ex_t exp;
        drive_id(1, 18, 19, 0, 0, 7, 1, 1, 0, 1, 4'h0, 32'h0, 32'h0, 32'h0);
        sb.push_back(mk(1, 1, 1, 0, 1, 7, 0, 32'h0, 32'h0, 32'h0));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL un_load got=%h exp=%h", got(), exp); end
        ex_alu = 32'h77;
        drive_id(1, 7, 7, 0, 0, 12, 1, 0, 0, 0, 4'h5, 32'h0, 32'h55, 32'h66);
        #1; checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL un_stall got=%b exp=%b", stall, 1'b0); end
`ifdef FORWARD_EN
        sb.push_back(mk(1, 1, 0, 0, 0, 12, 5, 32'h77, 32'h77, 32'h0));
`else
        sb.push_back(mk(1, 1, 0, 0, 0, 12, 5, 32'h55, 32'h66, 32'h0));
`endif
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL un_pass got=%h exp=%h", got(), exp); end
    endtask

    task automatic test_r0_flush();
        ex_t exp;
        drive_id(1, 18, 19, 0, 0, 0, 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL r0_prod got=%h exp=%h", got(), exp); end
        ex_alu = 32'h9;
        drive_mem(0, 1, 0, 32'h9, 32'h9);
        drive_id(1, 0, 0, 1, 1, 13, 1, 0, 0, 0, 4'h6, 32'h0, 32'h0, 32'h0);
        #1; checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%b exp=%b", stall, 1'b0); end
        sb.push_back(mk(1, 1, 0, 0, 0, 13, 6, 32'h0, 32'h0, 32'h0));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL r0_zero got=%h exp=%h", got(), exp); end
        drive_mem(0, 0, 0, 32'h0, 32'h0);
        flush = 1'b1;
        drive_id(1, 21, 22, 1, 1, 14, 1, 0, 1, 1, 4'h7, 32'h3, 32'h31, 32'h32);
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL flush got=%h exp=%h", got(), exp); end
        flush = 1'b0;
        drive_id(1, 18, 19, 0, 0, 2, 1, 1, 0, 1, 4'h0, 32'h8, 32'h0, 32'h0);
        sb.push_back(mk(1, 1, 1, 0, 1, 2, 0, 32'h0, 32'h0, 32'h8));
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL fs_load got=%h exp=%h", got(), exp); end
        flush = 1'b1;
        drive_id(1, 2, 23, 1, 0, 15, 1, 0, 0, 0, 4'h1, 32'h0, 32'h1, 32'h2);
        #1; checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fs_stall got=%b exp=%b", stall, 1'b1); end
        sb.push_back('0);
        @(posedge clock); #1;
        exp = sb.pop_front(); checks++;
        if (got() !== exp) begin errors++; $display("FAIL fs_bubble got=%h exp=%h", got(), exp); end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        ex_t exp;
        logic [31:0] ds, dt, imm;
        drive_mem(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            ds = $urandom; dt = $urandom; imm = $urandom;
            drive_id(1, 5'(16 + i), 5'(24 + i), 1, 1, 5'(8 + i), 1, 0, i[0], i[1],
                     4'(i), imm, ds, dt);
            sb.push_back(mk(1, 1, 0, i[0], i[1], 5'(8 + i), 4'(i), ds, dt, imm));
            #1; checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got=%b exp=%b", i, stall, 1'b0); end
            @(posedge clock); #1;
            exp = sb.pop_front(); checks++;
            if (got() !== exp) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, got(), exp); end
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; ex_alu = '0;
        drive_mem(0, 0, 0, 32'h0, 32'h0);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_unused();
        test_r0_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
